pll_dyn_ctrl: RTL and testbench

//  Supervises one Gowin GW5A PLL primitive on the reference-clock side.

---
 rtl/pll_dyn_ctrl_if.sv | 23 ++
 rtl/pll_dyn_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pll_dyn_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_dyn_ctrl_if.sv
// Divider-change request channel for pll_dyn_ctrl.
//   req_valid  master->slave  request strobe
//   req_ready  slave->master  controller can take a request this cycle
//   req_ch     master->slave  target PLL output index
//   req_div    master->slave  new output divider (2..127)
//   req_err    slave->master  one-cycle pulse: accepted request was rejected
interface pll_dyn_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_ch;
    logic [6:0] req_div;
    logic       req_err;

    modport master (
        output req_valid, req_ch, req_div,
        input  req_ready, req_err
    );

    modport slave (
        input  req_valid, req_ch, req_div,
        output req_ready, req_err
    );
endinterface

// File: rtl/pll_dyn_ctrl.sv
// Supervisor for one GW5A PLL on the reference-clock side: sequences PLL
// reset, qualifies lock, retries on lock timeout, and retunes output
// dividers at runtime through ODSEL with ENCLK gating around each change.
//   clk_i        reference clock (same net as PLL CLKIN)
//   resetn_i     synchronous active-low reset
//   pll_lock_i   PLL LOCK, asynchronous (synchronised here)
//   pll_reset_o  PLL RESET
//   odsel_o      ODSELn per output, Gowin encoding (128 - div) mod 128
//   enclk_o      ENCLKn per output
//   locked_o     qualified lock
//   busy_o       not in RUN
//   fail_o       retries exhausted (left only by reset)
//   req          divider-change request channel (slave side)
module pll_dyn_ctrl #(
    parameter int unsigned          NUM_OUT     = 3,
    parameter logic [7*NUM_OUT-1:0] ODIV_INIT   = {7'd75, 7'd8, 7'd8},
    parameter int unsigned          RST_CYC     = 64,
    parameter int unsigned          LOCK_CYC    = 1024,
    parameter int unsigned          TIMEOUT_CYC = 65536,
    parameter int unsigned          MAX_RETRY   = 3,
    parameter int unsigned          GATE_CYC    = 8
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic                 pll_lock_i,
    output logic                 pll_reset_o,
    output logic [7*NUM_OUT-1:0] odsel_o,
    output logic [NUM_OUT-1:0]   enclk_o,
    output logic                 locked_o,
    output logic                 busy_o,
    output logic                 fail_o,
    pll_dyn_ctrl_if.slave        req
);
    localparam int unsigned CMAX = (RST_CYC > GATE_CYC) ? RST_CYC : GATE_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned LW   = $clog2(LOCK_CYC + 1);
    localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned RW   = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        ST_RST_HOLD, ST_WAIT_LOCK, ST_RUN, ST_GATE_OFF, ST_GATE_ON, ST_FAIL
    } state_t;

    function automatic logic [6:0] enc7(input logic [6:0] div);
        return 7'(8'd128 - {1'b0, div});
    endfunction

    function automatic logic [7*NUM_OUT-1:0] init_odsel();
        logic [7*NUM_OUT-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++)
            r[7*i +: 7] = enc7(ODIV_INIT[7*i +: 7]);
        return r;
    endfunction

    localparam logic [7*NUM_OUT-1:0] ODSEL_RST = init_odsel();

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LW-1:0]        lcnt_q, lcnt_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic                 locked_q, locked_d;
    logic                 err_q, err_d;
    logic [2:0]           ch_q, ch_d;
    logic [6:0]           div_q, div_d;
    logic [7*NUM_OUT-1:0] odsel_q, odsel_d;
    logic                 lock_meta_q, lock_s_q;
    logic                 req_legal;

    // State register
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q     <= ST_RST_HOLD;
            cnt_q       <= '0;
            lcnt_q      <= '0;
            tcnt_q      <= '0;
            retry_q     <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            ch_q        <= '0;
            div_q       <= '0;
            odsel_q     <= ODSEL_RST;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcnt_q      <= lcnt_d;
            tcnt_q      <= tcnt_d;
            retry_q     <= retry_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            ch_q        <= ch_d;
            div_q       <= div_d;
            odsel_q     <= odsel_d;
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign req_legal = (32'(req.req_ch) < NUM_OUT) && (req.req_div >= 7'd2);

    // Next-state logic. Counters only advance below their terminal value,
    // so they can never wrap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lcnt_d   = lcnt_q;
        tcnt_d   = tcnt_q;
        retry_d  = retry_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        ch_d     = ch_q;
        div_d    = div_q;
        odsel_d  = odsel_q;
        case (state_q)
            ST_RST_HOLD: begin
                locked_d = 1'b0;
                if (cnt_q == CW'(RST_CYC - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    lcnt_d  = '0;
                    tcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Qualification wins over a timeout landing on the same cycle.
                if (lock_s_q && (lcnt_q == LW'(LOCK_CYC - 1))) begin
                    state_d  = ST_RUN;
                    locked_d = 1'b1;
                    retry_d  = '0;
                end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    retry_d = retry_q + 1'b1;
                    cnt_d   = '0;
                    state_d = (retry_q == RW'(MAX_RETRY - 1)) ? ST_FAIL : ST_RST_HOLD;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                    lcnt_d = lock_s_q ? lcnt_q + 1'b1 : '0;
                end
            end
            ST_RUN: begin
                retry_d = '0;
                if (!lock_s_q) begin
                    state_d  = ST_RST_HOLD;
                    locked_d = 1'b0;
                    cnt_d    = '0;
                end else if (req.req_valid) begin
                    if (req_legal) begin
                        state_d = ST_GATE_OFF;
                        ch_d    = req.req_ch;
                        div_d   = req.req_div;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_GATE_OFF, ST_GATE_ON: begin
                if (!lock_s_q) begin
                    state_d  = ST_RST_HOLD;
                    locked_d = 1'b0;
                    retry_d  = '0;
                    cnt_d    = '0;
                end else if (cnt_q == CW'(GATE_CYC - 1)) begin
                    cnt_d = '0;
                    if (state_q == ST_GATE_OFF) begin
                        odsel_d[7*int'(ch_q) +: 7] = enc7(div_q);
                        state_d = ST_GATE_ON;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_FAIL;
        endcase
    end

    // Outputs
    always_comb begin
        pll_reset_o   = 1'b0;
        enclk_o       = '0;
        req.req_ready = 1'b0;
        case (state_q)
            ST_RST_HOLD, ST_FAIL: pll_reset_o = 1'b1;
            ST_RUN: begin
                enclk_o       = '1;
                req.req_ready = lock_s_q;
            end
            ST_GATE_OFF, ST_GATE_ON: begin
                enclk_o = '1;
                for (int unsigned i = 0; i < NUM_OUT; i++)
                    if (i == 32'(ch_q)) enclk_o[i] = 1'b0;
            end
            default: ;
        endcase
    end

    // Lock loss is reflected the same cycle the synchronised lock drops.
    assign locked_o    = locked_q & lock_s_q;
    assign busy_o      = (state_q != ST_RUN);
    assign fail_o      = (state_q == ST_FAIL);
    assign odsel_o     = odsel_q;
    assign req.req_err = err_q;
endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl with shortened timing parameters.
module tb_pll_dyn_ctrl;
    localparam int unsigned RST_C  = 16;
    localparam int unsigned LOCK_C = 32;
    localparam int unsigned TMO_C  = 100;
    localparam int unsigned GATE_C = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pll_lock;
    logic        pll_reset;
    logic [20:0] odsel;
    logic [2:0]  enclk;
    logic        locked, busy, fail;

    int unsigned total = 0;
    int unsigned bad   = 0;

    pll_dyn_ctrl_if bus ();

    pll_dyn_ctrl #(
        .NUM_OUT    (3),
        .ODIV_INIT  ({7'd75, 7'd8, 7'd8}),
        .RST_CYC    (RST_C),
        .LOCK_CYC   (LOCK_C),
        .TIMEOUT_CYC(TMO_C),
        .MAX_RETRY  (3),
        .GATE_CYC   (GATE_C)
    ) dut (
        .clk_i      (clk),
        .resetn_i   (resetn),
        .pll_lock_i (pll_lock),
        .pll_reset_o(pll_reset),
        .odsel_o    (odsel),
        .enclk_o    (enclk),
        .locked_o   (locked),
        .busy_o     (busy),
        .fail_o     (fail),
        .req        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ch;
        logic [6:0] div;
        bit         err;
        logic [6:0] enc;
    } vec_t;

    vec_t        vecs[8];
    logic [20:0] exp_odsel;
    logic [20:0] rst_odsel;
    logic [2:0]  emask;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_reset"}, 32'(pll_reset), 1);
        chk({tag, "_enclk"}, 32'(enclk), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_fail"}, 32'(fail), 0);
        chk({tag, "_req_err"}, 32'(bus.req_err), 0);
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_odsel"}, 32'(odsel), 32'(rst_odsel));
    endtask

    task automatic send(input logic [2:0] ch, input logic [6:0] div);
        bus.req_valid = 1'b1;
        bus.req_ch    = ch;
        bus.req_div   = div;
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int unsigned n;
        // ch, div, expect-error, expected ODSEL field
        vecs[0] = '{3'd1, 7'd10,  1'b0, 7'd118};
        vecs[1] = '{3'd5, 7'd10,  1'b1, 7'd0};
        vecs[2] = '{3'd0, 7'd1,   1'b1, 7'd0};
        vecs[3] = '{3'd0, 7'd0,   1'b1, 7'd0};
        vecs[4] = '{3'd3, 7'd50,  1'b1, 7'd0};
        vecs[5] = '{3'd0, 7'd2,   1'b0, 7'd126};
        vecs[6] = '{3'd2, 7'd127, 1'b0, 7'd1};
        vecs[7] = '{3'd2, 7'd64,  1'b0, 7'd64};
        rst_odsel = {7'd53, 7'd120, 7'd120};
        exp_odsel = rst_odsel;

        resetn        = 1'b0;
        pll_lock      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_ch    = '0;
        bus.req_div   = '0;
        repeat (2) tick();
        chk_reset_vals("reset");

        // Bring-up: pll_reset released after RST_C edges, lock qualified
        // LOCK_C synchronised-lock cycles after the sync pipeline fills.
        resetn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15) chk("rst_hold_last", 32'(pll_reset), 1);
            if (i == 16) chk("rst_released", 32'(pll_reset), 0);
        end
        pll_lock = 1'b1;
        for (int i = 21; i <= 54; i++) begin
            tick();
            if (i == 53) chk("lock_not_yet", 32'(locked), 0);
            if (i == 54) chk("lock_qualified", 32'(locked), 1);
        end
        chk("run_enclk", 32'(enclk), 7);
        chk("run_ready", 32'(bus.req_ready), 1);
        chk("run_busy", 32'(busy), 0);

        // Table-driven requests in RUN
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].ch, vecs[v].div);
            if (vecs[v].err) begin
                chk("err_pulse", 32'(bus.req_err), 1);
                chk("err_ready", 32'(bus.req_ready), 1);
                tick();
                chk("err_pulse_end", 32'(bus.req_err), 0);
                chk("err_odsel", 32'(odsel), 32'(exp_odsel));
                chk("err_enclk", 32'(enclk), 7);
            end else begin
                emask = 3'b111;
                emask[vecs[v].ch] = 1'b0;
                chk("gate_ready", 32'(bus.req_ready), 0);
                for (int j = 0; j < 2 * int'(GATE_C); j++) begin
                    chk("gate_enclk", 32'(enclk), 32'(emask));
                    if (j == int'(GATE_C) - 1) chk("gate_odsel_old", 32'(odsel), 32'(exp_odsel));
                    if (j == int'(GATE_C)) begin
                        exp_odsel[7*vecs[v].ch +: 7] = vecs[v].enc;
                        chk("gate_odsel_new", 32'(odsel), 32'(exp_odsel));
                    end
                    tick();
                end
                chk("gate_done_enclk", 32'(enclk), 7);
                chk("gate_done_ready", 32'(bus.req_ready), 1);
                chk("gate_done_odsel", 32'(odsel), 32'(exp_odsel));
            end
        end

        // Lock loss while gating, after ODSEL is written
        send(3'd0, 7'd20);
        repeat (GATE_C) tick();
        exp_odsel[6:0] = 7'd108;
        chk("drop_odsel_written", 32'(odsel), 32'(exp_odsel));
        pll_lock = 1'b0;
        tick();
        chk("drop_locked_before", 32'(locked), 1);
        tick();
        chk("drop_locked_same_cyc", 32'(locked), 0);
        tick();
        chk("drop_pll_reset", 32'(pll_reset), 1);
        chk("drop_enclk", 32'(enclk), 0);
        pll_lock = 1'b1;
        n = 0;
        while (!locked && n < 300) begin
            tick();
            n++;
        end
        chk("requalify", 32'(locked), 1);
        chk("requalify_odsel", 32'(odsel), 32'(exp_odsel));
        chk("requalify_enclk", 32'(enclk), 7);

        // Reset in the middle of GATE_ON
        send(3'd2, 7'd30);
        repeat (GATE_C + 2) tick();
        exp_odsel[20:14] = 7'd98;
        chk("gate_on_odsel", 32'(odsel), 32'(exp_odsel));
        resetn = 1'b0;
        tick();
        chk_reset_vals("midgate_reset");

        // Lock never asserts: three attempts, then FAIL
        pll_lock = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 1; i <= 348; i++) begin
            tick();
            if (i == 115) chk("att1_wait", 32'(pll_reset), 0);
            if (i == 116) chk("att1_retry", 32'(pll_reset), 1);
            if (i == 347) chk("fail_not_yet", 32'(fail), 0);
        end
        chk("fail_set", 32'(fail), 1);
        chk("fail_pll_reset", 32'(pll_reset), 1);
        chk("fail_ready", 32'(bus.req_ready), 0);
        pll_lock = 1'b1;
        repeat (60) tick();
        chk("fail_sticky", 32'(fail), 1);
        chk("fail_locked", 32'(locked), 0);
        chk("fail_enclk", 32'(enclk), 0);
        resetn = 1'b0;
        tick();
        chk("fail_cleared", 32'(fail), 0);
        resetn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
